// File: rtl/ahblite_master.sv
// AHB-Lite initiator: takes commands on a valid/ready port and issues single or INCR
// transfers with pipelined address/data phases, returning one response per completed beat.
module ahblite_master #(
  parameter int         MAXLEN_W  = 4,
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic                hclk,
  input  logic                hreset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [31:0]         cmd_addr,
  input  logic [2:0]          cmd_size,
  input  logic [MAXLEN_W-1:0] cmd_len,
  input  logic [31:0]         wd_data,
  output logic                wd_pop,
  output logic                rsp_valid,
  output logic [31:0]         rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_last,
  output logic [31:0]         haddr,
  output logic [1:0]          htrans,
  output logic                hwrite,
  output logic [2:0]          hsize,
  output logic [2:0]          hburst,
  output logic [3:0]          hprot,
  output logic [31:0]         hwdata,
  input  logic [31:0]         hrdata,
  input  logic                hready,
  input  logic                hresp
);
  // state  | meaning
  // S_IDLE | ready for a command, bus idle
  // S_ADDR | address phase on the bus, possibly overlapping previous data phase
  // S_LAST | final data phase, htrans idle
  // S_ERR  | waiting for the second cycle of an ERROR response
  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_LAST, S_ERR} state_t;

  localparam int             CNT_W      = MAXLEN_W + 1;
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [1:0]     TR_IDLE    = 2'b00;
  localparam logic [1:0]     TR_NONSEQ  = 2'b10;
  localparam logic [1:0]     TR_SEQ     = 2'b11;

  state_t           state;
  logic [CNT_W-1:0] addr_left;
  logic [CNT_W-1:0] data_left;
  logic             dphase;
  logic             dphase_write;
  logic             cmd_fire;
  logic             cmd_bad;
  logic             addr_done;
  logic             data_done;
  logic             err_first;
  logic             err_term;
  logic [31:0]      next_addr;

  assign hprot     = HPROT_VAL;
  assign cmd_fire  = (state == S_IDLE) && cmd_ready && cmd_valid;
  assign addr_done = (state == S_ADDR) && htrans[1] && hready && !hresp;
  assign data_done = dphase && hready && !hresp;
  assign err_first = dphase && hresp && !hready;
  assign err_term  = dphase && hresp && hready;
  assign next_addr = haddr + (32'd1 << hsize);
  // Combinational so the source advances on the same edge that captures the beat.
  assign wd_pop    = addr_done && hwrite && !hreset;

  always_comb begin
    cmd_bad = 1'b0;
    case (cmd_size)
      3'd0:    cmd_bad = 1'b0;
      3'd1:    cmd_bad = cmd_addr[0];
      3'd2:    cmd_bad = |cmd_addr[1:0];
      default: cmd_bad = 1'b1;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state        <= S_IDLE;
      cmd_ready    <= 1'b0;
      htrans       <= TR_IDLE;
      haddr        <= '0;
      hwrite       <= 1'b0;
      hsize        <= '0;
      hburst       <= '0;
      hwdata       <= '0;
      rsp_valid    <= 1'b0;
      rsp_err      <= 1'b0;
      rsp_last     <= 1'b0;
      rsp_rdata    <= '0;
      addr_left    <= '0;
      data_left    <= '0;
      dphase       <= 1'b0;
      dphase_write <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_last  <= 1'b0;
      rsp_rdata <= '0;
      case (state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_fire) begin
            if (cmd_bad) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_last  <= 1'b1;
            end else begin
              cmd_ready <= 1'b0;
              state     <= S_ADDR;
              htrans    <= TR_NONSEQ;
              haddr     <= cmd_addr;
              hwrite    <= cmd_write;
              hsize     <= cmd_size;
              hburst    <= (cmd_len == '0) ? 3'b000 : 3'b001;
              addr_left <= {1'b0, cmd_len} + ONE;
              data_left <= {1'b0, cmd_len} + ONE;
            end
          end
        end
        S_ADDR, S_LAST: begin
          if (err_first) begin
            htrans <= TR_IDLE;
            dphase <= 1'b0;
            state  <= S_ERR;
          end else if (err_term) begin
            htrans    <= TR_IDLE;
            dphase    <= 1'b0;
            addr_left <= '0;
            data_left <= '0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_last  <= 1'b1;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end else if (hready) begin
            if (data_done) begin
              rsp_valid <= 1'b1;
              rsp_rdata <= dphase_write ? 32'd0 : hrdata;
              rsp_last  <= (data_left == ONE);
              if (data_left != '0) data_left <= data_left - ONE;
            end
            if (addr_done) begin
              dphase       <= 1'b1;
              dphase_write <= hwrite;
              if (hwrite) hwdata <= wd_data;
              if (addr_left != '0) addr_left <= addr_left - ONE;
              if (addr_left == ONE) begin
                htrans <= TR_IDLE;
                state  <= S_LAST;
              end else begin
                haddr  <= next_addr;
                // A 1KB boundary restarts the burst with a NONSEQ beat.
                htrans <= (next_addr[9:0] == 10'd0) ? TR_NONSEQ : TR_SEQ;
              end
            end else begin
              dphase <= 1'b0;
              if (state == S_LAST) begin
                cmd_ready <= 1'b1;
                state     <= S_IDLE;
              end
            end
          end
        end
        S_ERR: begin
          if (hready) begin
            addr_left <= '0;
            data_left <= '0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_last  <= 1'b1;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ahblite_master.sv
// Directed bench for ahblite_master: a small AHB slave model supplies hready/hresp/hrdata,
// each test task drives one scenario and compares against hand-computed values.
module tb_ahblite_master;
  logic        hclk = 1'b0;
  logic        hreset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [2:0]  cmd_size = '0;
  logic [3:0]  cmd_len = '0;
  logic [31:0] wd_data = '0;
  logic        wd_pop;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_last;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic [31:0] hrdata = '0;
  logic        hready = 1'b1;
  logic        hresp = 1'b0;

  ahblite_master dut (
    .hclk(hclk), .hreset(hreset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_len(cmd_len),
    .wd_data(wd_data), .wd_pop(wd_pop),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_last(rsp_last),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
    .hprot(hprot), .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp)
  );

  always #5 hclk = ~hclk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] q_addr[$];
  logic [1:0]  q_trans[$];
  logic [2:0]  q_burst[$];
  logic [2:0]  q_size[$];
  logic [31:0] q_hwdata[$];
  logic [31:0] q_rdata[$];
  logic        q_err[$];
  logic        q_last[$];
  int          pops, hold_viol, post_act, bus_act;
  logic [1:0]  err2_trans;
  int          stall_beat = 0, stall_len = 0, err_beat = 0;
  logic [31:0] wd_base = '0;

  // Presents one command, plays the slave, and records bus/response activity.
  task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                         input logic [3:0] len, input int rst_at, output bit timeout);
    bit acc, done, dp_pending, dp_write, e2;
    int cycles, extra, dp_beat, err_ph, stall_cnt;
    logic [31:0] dp_addr, prev_haddr;
    logic [1:0]  prev_htrans;
    logic        prev_hready, prev_hresp;
    q_addr.delete(); q_trans.delete(); q_burst.delete(); q_size.delete();
    q_hwdata.delete(); q_rdata.delete(); q_err.delete(); q_last.delete();
    pops = 0; hold_viol = 0; post_act = 0; bus_act = 0; err2_trans = 2'b01;
    acc = 0; done = 0; dp_pending = 0; dp_write = 0; dp_addr = '0;
    cycles = 0; extra = 0; dp_beat = 0; err_ph = 0; stall_cnt = 0;
    prev_haddr = '0; prev_htrans = '0; prev_hready = 1'b1; prev_hresp = 1'b0;
    cmd_write = wr; cmd_addr = addr; cmd_size = size; cmd_len = len;
    timeout = 1;
    while (cycles < 300 && extra < 5) begin
      @(negedge hclk);
      cycles++;
      e2 = 0;
      cmd_valid = !acc;
      wd_data = wd_base + pops;
      if (rst_at != 0 && cycles == rst_at) begin
        hreset = 1'b1;
        cmd_valid = 1'b0;
        timeout = 0;
        return;
      end
      hready = 1'b1; hresp = 1'b0;
      hrdata = dp_pending ? (32'hD000_0000 | dp_addr) : 32'h0;
      if (dp_pending && dp_beat == err_beat) begin
        hresp = 1'b1;
        if (err_ph == 0) begin hready = 1'b0; err_ph = 1; end
        else begin err_ph = 2; e2 = 1; end
      end else if (dp_pending && dp_beat == stall_beat && stall_cnt < stall_len) begin
        hready = 1'b0;
        stall_cnt++;
      end
      #1;
      if (e2) err2_trans = htrans;
      if (done) begin
        extra++;
        if (htrans != 2'b00 || rsp_valid) post_act++;
      end else begin
        if (htrans != 2'b00) bus_act++;
        if (rsp_valid) begin
          q_rdata.push_back(rsp_rdata); q_err.push_back(rsp_err); q_last.push_back(rsp_last);
          if (rsp_last) begin done = 1; timeout = 0; end
        end
      end
      if (wd_pop) pops++;
      if (htrans != 2'b00 && hready && !hresp) begin
        q_addr.push_back(haddr); q_trans.push_back(htrans);
        q_burst.push_back(hburst); q_size.push_back(hsize);
      end
      if (dp_pending && dp_write && hready && !hresp) q_hwdata.push_back(hwdata);
      if (!prev_hready && !prev_hresp && prev_htrans != 2'b00 &&
          (haddr != prev_haddr || htrans != prev_htrans)) hold_viol++;
      prev_haddr = haddr; prev_htrans = htrans; prev_hready = hready; prev_hresp = hresp;
      if (cmd_valid && cmd_ready) acc = 1;
      if (hready) begin
        if (htrans != 2'b00 && !hresp) begin
          dp_pending = 1; dp_addr = haddr; dp_write = hwrite; dp_beat++; stall_cnt = 0;
        end else dp_pending = 0;
      end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [127:0] v;
    hreset = 1'b1;
    repeat (3) @(negedge hclk);
    #1;
    v = {htrans, haddr, hwrite, hsize, hburst, hwdata, rsp_valid, rsp_err, rsp_last,
         rsp_rdata, wd_pop, cmd_ready};
    n_cmp++;
    if (v !== '0) begin n_bad++; $display("FAIL reset_outputs: got %h want 0", v); end
    n_cmp++;
    if (hprot !== 4'b0011) begin n_bad++; $display("FAIL reset_hprot: got %h want 3", hprot); end
    hreset = 1'b0;
    @(negedge hclk); #1;
    n_cmp++;
    if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_release_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_single_write();
    bit to;
    wd_base = 32'hA5A5_A5A5; stall_beat = 0; stall_len = 0; err_beat = 0;
    run_cmd(1'b1, 32'h100, 3'd2, 4'd0, 0, to);
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL single_wr_timeout: no rsp_last within budget"); end
    n_cmp++;
    if (q_addr.size() != 1 || q_addr[0] !== 32'h100 || q_trans[0] !== 2'b10 ||
        q_burst[0] !== 3'b000 || q_size[0] !== 3'd2) begin
      n_bad++;
      $display("FAIL single_wr_addr: n=%0d addr=%h trans=%b burst=%0d size=%0d want 1 100 10 0 2",
               q_addr.size(), q_addr[0], q_trans[0], q_burst[0], q_size[0]);
    end
    n_cmp++;
    if (pops != 1) begin n_bad++; $display("FAIL single_wr_pops: got %0d want 1", pops); end
    n_cmp++;
    if (q_hwdata.size() != 1 || q_hwdata[0] !== 32'hA5A5_A5A5) begin
      n_bad++; $display("FAIL single_wr_hwdata: n=%0d got %h want a5a5a5a5", q_hwdata.size(), q_hwdata[0]);
    end
    n_cmp++;
    if (q_last.size() != 1 || q_last[0] !== 1'b1 || q_err[0] !== 1'b0 || q_rdata[0] !== 32'h0) begin
      n_bad++;
      $display("FAIL single_wr_rsp: n=%0d last=%b err=%b rdata=%h want 1 1 0 0",
               q_last.size(), q_last[0], q_err[0], q_rdata[0]);
    end
    n_cmp++;
    if (post_act != 0) begin n_bad++; $display("FAIL single_wr_post: got %0d extra cycles want 0", post_act); end
  endtask

  task automatic test_read_stall();
    bit to;
    stall_beat = 2; stall_len = 2; err_beat = 0;
    run_cmd(1'b0, 32'h200, 3'd2, 4'd3, 0, to);
    n_cmp++;
    if (to || q_addr.size() != 4 || q_rdata.size() != 4) begin
      n_bad++; $display("FAIL rd_counts: to=%0d addr=%0d rsp=%0d want 0 4 4", to, q_addr.size(), q_rdata.size());
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (q_addr[i] !== 32'h200 + 32'(4 * i) || q_trans[i] !== ((i == 0) ? 2'b10 : 2'b11) ||
          q_burst[i] !== 3'b001) begin
        n_bad++; $display("FAIL rd_addr[%0d]: addr=%h trans=%b burst=%0d", i, q_addr[i], q_trans[i], q_burst[i]);
      end
      n_cmp++;
      if (q_rdata[i] !== 32'hD000_0200 + 32'(4 * i) || q_err[i] !== 1'b0 || q_last[i] !== (i == 3)) begin
        n_bad++; $display("FAIL rd_rsp[%0d]: rdata=%h err=%b last=%b", i, q_rdata[i], q_err[i], q_last[i]);
      end
    end
    n_cmp++;
    if (hold_viol != 0 || pops != 0) begin
      n_bad++; $display("FAIL rd_hold: hold_viol=%0d pops=%0d want 0 0", hold_viol, pops);
    end
  endtask

  task automatic test_1k_cross_write();
    bit to;
    logic [31:0] ea [4];
    logic [1:0]  et [4];
    ea = '{32'h3F8, 32'h3FC, 32'h400, 32'h404};
    et = '{2'b10, 2'b11, 2'b10, 2'b11};
    wd_base = 32'h1000_0000; stall_beat = 0; stall_len = 0; err_beat = 0;
    run_cmd(1'b1, 32'h3F8, 3'd2, 4'd3, 0, to);
    n_cmp++;
    if (to || pops != 4 || q_addr.size() != 4 || q_hwdata.size() != 4) begin
      n_bad++;
      $display("FAIL wr1k_counts: to=%0d pops=%0d addr=%0d hwdata=%0d want 0 4 4 4",
               to, pops, q_addr.size(), q_hwdata.size());
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (q_addr[i] !== ea[i] || q_trans[i] !== et[i] || q_burst[i] !== 3'b001) begin
        n_bad++;
        $display("FAIL wr1k_beat[%0d]: addr=%h trans=%b burst=%0d want %h %b 1",
                 i, q_addr[i], q_trans[i], q_burst[i], ea[i], et[i]);
      end
      n_cmp++;
      if (q_hwdata[i] !== 32'h1000_0000 + 32'(i)) begin
        n_bad++; $display("FAIL wr1k_hwdata[%0d]: got %h want %h", i, q_hwdata[i], 32'h1000_0000 + 32'(i));
      end
    end
  endtask

  task automatic test_error();
    bit to;
    stall_beat = 0; stall_len = 0; err_beat = 3;
    run_cmd(1'b0, 32'h500, 3'd2, 4'd7, 0, to);
    err_beat = 0;
    n_cmp++;
    if (to || q_rdata.size() != 3 || q_addr.size() != 3) begin
      n_bad++; $display("FAIL err_counts: to=%0d rsp=%0d addr=%0d want 0 3 3", to, q_rdata.size(), q_addr.size());
    end
    n_cmp++;
    if (q_rdata[0] !== 32'hD000_0500 || q_rdata[1] !== 32'hD000_0504 ||
        q_err[0] !== 1'b0 || q_err[1] !== 1'b0 || q_last[0] !== 1'b0 || q_last[1] !== 1'b0) begin
      n_bad++; $display("FAIL err_good_beats: rdata=%h %h err=%b%b last=%b%b",
                        q_rdata[0], q_rdata[1], q_err[0], q_err[1], q_last[0], q_last[1]);
    end
    n_cmp++;
    if (q_err[2] !== 1'b1 || q_last[2] !== 1'b1) begin
      n_bad++; $display("FAIL err_beat3: err=%b last=%b want 1 1", q_err[2], q_last[2]);
    end
    n_cmp++;
    if (err2_trans !== 2'b00) begin n_bad++; $display("FAIL err_htrans2: got %b want 00", err2_trans); end
    n_cmp++;
    if (post_act != 0) begin n_bad++; $display("FAIL err_post: got %0d want 0", post_act); end
  endtask

  task automatic test_reject();
    bit to;
    logic [31:0] ra [2];
    logic [2:0]  rs [2];
    ra = '{32'h100, 32'h102};
    rs = '{3'd3, 3'd2};
    for (int k = 0; k < 2; k++) begin
      run_cmd(1'b0, ra[k], rs[k], 4'd0, 0, to);
      n_cmp++;
      if (to || q_err.size() != 1 || q_err[0] !== 1'b1 || q_last[0] !== 1'b1) begin
        n_bad++; $display("FAIL reject[%0d]_rsp: to=%0d n=%0d err=%b last=%b want 0 1 1 1",
                          k, to, q_err.size(), q_err[0], q_last[0]);
      end
      n_cmp++;
      if (bus_act != 0 || post_act != 0) begin
        n_bad++; $display("FAIL reject[%0d]_bus: bus=%0d post=%0d want 0 0", k, bus_act, post_act);
      end
    end
  endtask

  task automatic test_sizes();
    bit to;
    run_cmd(1'b0, 32'h40, 3'd1, 4'd1, 0, to);
    n_cmp++;
    if (to || q_addr.size() != 2 || q_addr[0] !== 32'h40 || q_addr[1] !== 32'h42 ||
        q_size[1] !== 3'd1 || q_rdata[1] !== 32'hD000_0042 || q_last[1] !== 1'b1) begin
      n_bad++; $display("FAIL half_rd: n=%0d addr=%h %h size=%0d rdata=%h last=%b",
                        q_addr.size(), q_addr[0], q_addr[1], q_size[1], q_rdata[1], q_last[1]);
    end
    run_cmd(1'b0, 32'h7, 3'd0, 4'd2, 0, to);
    n_cmp++;
    if (to || q_addr.size() != 3 || q_addr[2] !== 32'h9 || q_trans[2] !== 2'b11 ||
        q_size[0] !== 3'd0 || q_rdata[2] !== 32'hD000_0009 || q_rdata.size() != 3) begin
      n_bad++; $display("FAIL byte_rd: n=%0d addr2=%h trans2=%b size=%0d rdata2=%h",
                        q_addr.size(), q_addr[2], q_trans[2], q_size[0], q_rdata[2]);
    end
  endtask

  task automatic test_reset_mid_burst();
    bit to;
    logic [127:0] v;
    wd_base = 32'h0; stall_beat = 0; stall_len = 0; err_beat = 0;
    run_cmd(1'b1, 32'h1000, 3'd2, 4'd15, 10, to);
    n_cmp++;
    if (pops == 0) begin n_bad++; $display("FAIL rstmid_started: pops=%0d want >0", pops); end
    @(negedge hclk); #1;
    v = {htrans, haddr, hwrite, hsize, hburst, hwdata, rsp_valid, rsp_err, rsp_last,
         rsp_rdata, wd_pop, cmd_ready};
    n_cmp++;
    if (v !== '0) begin n_bad++; $display("FAIL rstmid_outputs: got %h want 0", v); end
    hreset = 1'b0;
    wd_base = 32'h55;
    run_cmd(1'b1, 32'h2000, 3'd2, 4'd1, 0, to);
    n_cmp++;
    if (to || q_last.size() != 2 || q_last[0] !== 1'b0 || q_last[1] !== 1'b1 ||
        q_err[0] !== 1'b0 || q_err[1] !== 1'b0 || pops != 2) begin
      n_bad++; $display("FAIL rstmid_new_rsp: to=%0d n=%0d last=%b%b err=%b%b pops=%0d",
                        to, q_last.size(), q_last[0], q_last[1], q_err[0], q_err[1], pops);
    end
    n_cmp++;
    if (q_addr[0] !== 32'h2000 || q_addr[1] !== 32'h2004 ||
        q_hwdata[0] !== 32'h55 || q_hwdata[1] !== 32'h56) begin
      n_bad++; $display("FAIL rstmid_new_data: addr=%h %h hwdata=%h %h want 2000 2004 55 56",
                        q_addr[0], q_addr[1], q_hwdata[0], q_hwdata[1]);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_stall();
    test_1k_cross_write();
    test_error();
    test_reject();
    test_sizes();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
